result_display: RTL and testbench

//   Output side of the calculator datapath. Latches a binary result on a load

---
 rtl/result_display.sv | 175 +++++++++++++++++
 tb/tb_result_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/result_display.sv
// Latches a binary result, converts it to BCD by double-dabble (one shift per
// cycle) and scans it onto a common-anode 7-segment display. Option: LEADING_ZERO_BLANK_EN.
module result_display #(
    parameter int VALUE_W  = 32,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VALUE_W-1:0] value,
    input  logic               load,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic [DIGITS-1:0]  an,
    output logic [6:0]         seg
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_W + 1);
    localparam int SC_W  = $clog2(SCAN_DIV + 1);
    localparam int IDX_W = $clog2(DIGITS + 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam longint unsigned LIMIT = pow10(DIGITS);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CONV, S_SHOW} state_t;

    state_t             r_state, w_state_nxt;
    logic [VALUE_W-1:0] r_shift;
    logic [BCD_W-1:0]   r_bcd, w_bcd_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_pend, r_ovf;
    logic [BCD_W-1:0]   r_digits;
    logic [DIGITS-1:0]  r_blank, w_blank;
    logic [SC_W-1:0]    r_scan_cnt;
    logic [IDX_W-1:0]   r_idx;
    logic               r_scan_en;
    logic               w_too_big;
    logic [3:0]         w_nib;

    assign w_too_big = 64'(r_shift) >= LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE:  if (load) w_state_nxt = S_CHECK;
            S_CHECK: begin
                busy        = 1'b1;
                w_state_nxt = w_too_big ? S_SHOW : S_CONV;
            end
            S_CONV: begin
                busy = 1'b1;
                if (r_cnt == CNT_W'(1)) w_state_nxt = S_SHOW;
            end
            S_SHOW: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        logic w_lead;
        w_lead  = 1'b1;
        w_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_lead     = w_lead & (r_bcd[4*i +: 4] == 4'd0);
            w_blank[i] = w_lead;
        end
    end
`else
    assign w_blank = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_digits   <= '0;
            r_blank    <= '0;
        end else begin
            case (r_state)
                S_IDLE:  if (load) r_shift <= value;
                S_CHECK: begin
                    r_ovf_pend <= w_too_big;
                    r_bcd      <= '0;
                    r_cnt      <= CNT_W'(VALUE_W);
                end
                S_CONV: begin
                    r_bcd   <= {w_bcd_adj[BCD_W-2:0], r_shift[VALUE_W-1]};
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt - 1'b1;
                end
                S_SHOW: begin
                    // On overflow the old digits stay; the dash glyph overrides them.
                    r_ovf <= r_ovf_pend;
                    if (!r_ovf_pend) begin
                        r_digits <= r_bcd;
                        r_blank  <= w_blank;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_idx      <= '0;
            r_scan_en  <= 1'b0;
        end else begin
            r_scan_en <= 1'b1;
            if (r_scan_cnt == SC_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    assign ovf   = r_ovf;
    assign w_nib = r_digits[int'(r_idx)*4 +: 4];
    assign an    = r_scan_en ? ~(DIGITS'(1) << r_idx) : '1;

    always_comb begin
        seg = 7'h7F;
        if (r_scan_en) begin
            if (r_ovf)                seg = 7'b0111111;
            else if (r_blank[r_idx])  seg = 7'h7F;
            else begin
                case (w_nib)
                    4'd0:    seg = 7'h40;
                    4'd1:    seg = 7'h79;
                    4'd2:    seg = 7'h24;
                    4'd3:    seg = 7'h30;
                    4'd4:    seg = 7'h19;
                    4'd5:    seg = 7'h12;
                    4'd6:    seg = 7'h02;
                    4'd7:    seg = 7'h78;
                    4'd8:    seg = 7'h00;
                    4'd9:    seg = 7'h10;
                    default: seg = 7'h7F;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_result_display.sv
// Directed + randomized bench for result_display with a decimal reference model.
module tb_result_display;
    localparam int VALUE_W  = 32;
    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [VALUE_W-1:0] value = '0;
    logic               load = 1'b0;
    logic               busy, done, ovf;
    logic [DIGITS-1:0]  an;
    logic [6:0]         seg;

    int n_cmp = 0;
    int n_err = 0;

    result_display #(.VALUE_W(VALUE_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load),
        .busy(busy), .done(done), .ovf(ovf), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic longint unsigned p10(input int n);
        longint unsigned p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [6:0] exp_seg(input longint unsigned v, input int i);
        if (v >= p10(DIGITS)) return 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
        if (i > 0 && v < p10(i)) return 7'h7F;
`endif
        return glyph[int'((v / p10(i)) % 10)];
    endfunction

    task automatic chk(input string tag, input longint obs, input longint expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_and_wait(input logic [31:0] v, input int inj_k, input logic [31:0] inj_v,
                                 output int lat, output int ndone, output int nbusy);
        @(negedge clk); load = 1'b1; value = v;
        @(negedge clk); load = 1'b0; value = $urandom;
        lat = -1; ndone = 0; nbusy = 0;
        for (int k = 1; k <= VALUE_W + 8; k++) begin
            if (done) begin ndone++; if (lat < 0) lat = k; end
            if (busy) nbusy++;
            if (k == inj_k) begin load = 1'b1; value = inj_v; end
            else load = 1'b0;
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    // Watches two full scan rotations: every sample must be one selected
    // digit showing the model glyph, advancing in order every SCAN_DIV cycles.
    task automatic check_display(input longint unsigned v);
        int prev = -1, run = 0, changes = 0, idx;
        logic [DIGITS-1:0] pat;
        chk("ovf", ovf, (v >= p10(DIGITS)));
        for (int s = 0; s < 2 * DIGITS * SCAN_DIV; s++) begin
            idx = -1;
            for (int i = 0; i < DIGITS; i++) begin
                pat = ~(DIGITS'(1) << i);
                if (an === pat) idx = i;
            end
            chk("an_onehot", (idx >= 0), 1);
            if (idx >= 0) begin
                chk($sformatf("seg_d%0d_v%0d", idx, v), seg, exp_seg(v, idx));
                if (prev >= 0 && idx != prev) begin
                    chk("scan_order", idx, (prev + 1) % DIGITS);
                    if (changes > 0) chk("scan_dwell", run, SCAN_DIV);
                    changes++;
                    run = 0;
                end
                run++;
                prev = idx;
            end
            @(negedge clk);
        end
        chk("scan_changes", (changes >= 2 * DIGITS - 1), 1);
    endtask

    task automatic conv(input logic [31:0] v, input int inj_k, input logic [31:0] inj_v);
        int lat, nd, nb;
        bit big;
        big = (longint'(v) >= p10(DIGITS));
        load_and_wait(v, inj_k, inj_v, lat, nd, nb);
        chk($sformatf("latency_v%0d", v), lat, big ? 2 : VALUE_W + 2);
        chk($sformatf("done_count_v%0d", v), nd, 1);
        chk($sformatf("busy_cycles_v%0d", v), nb, big ? 1 : VALUE_W + 1);
        check_display(longint'(v));
    endtask

    initial begin
        int lat, nd, nb;
        longint unsigned last;
        #1;
        chk("rst_an", an, {DIGITS{1'b1}});
        chk("rst_seg", seg, 7'h7F);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_display(0);

        conv(1234, 0, 0);
        conv(10000, 0, 0);
        conv(9999, 0, 0);
        conv(7, 0, 0);
        conv(0, 0, 0);
        conv(42, 5, 99);                   // load while busy is dropped
        conv(5678, VALUE_W + 2, 1111);     // load during SHOW is dropped
        conv(32'hFFFF_FFFF, 0, 0);
        last = 0;
        for (int r = 0; r < 8; r++) begin
            logic [31:0] v;
            v = (r % 3 == 2) ? $urandom : $urandom_range(0, 12000);
            conv(v, 0, 0);
            if (longint'(v) < p10(DIGITS)) last = v;
        end
        conv(9, 0, 0);

        // Reset in the middle of a conversion
        @(negedge clk); load = 1'b1; value = 3210;
        @(negedge clk); load = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_an", an, {DIGITS{1'b1}});
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", ovf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int k = 0; k < VALUE_W + 10; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("no_done_after_rst", nd, 0);
        check_display(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
